// File: rtl/risc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC control unit.
// The TRAP state exists only when ALU_CTRL_ILLEGAL_TRAP_EN is defined.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  // Operation class handed to the ALU decoder; selects which funct table applies.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BR
  } op_class_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_NOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BLTU = 3'b110;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REGA  = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  // beq compares for equality (Zero set); the others branch when the ALU result is non-zero.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return (funct3 == F3_BEQ) ? zero : !zero;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU control decode: {operation class, funct3, funct7[5]} -> ALUControl code
// plus a flag for funct combinations the datapath does not implement.
module alu_op_decoder
  import risc_ctrl_pkg::*;
(
  input  logic [2:0] op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves it unassigned (no latch).
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    unique case (op_class_e'(op_class))
      CLS_R: begin
        case (funct3)
          F3_ADD:  alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_control = ALU_AND;
          F3_OR:   alu_control = ALU_OR;
          F3_SLT:  alu_control = ALU_SLT;
          F3_SLTU: alu_control = ALU_SLTU;
          F3_NOR: begin
            if (funct7_b5) alu_control = ALU_NOR;
            else           illegal     = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      CLS_I: begin
        case (funct3)
          F3_ADD:  alu_control = ALU_ADD;
          F3_AND:  alu_control = ALU_AND;
          F3_OR:   alu_control = ALU_OR;
          F3_SLT:  alu_control = ALU_SLT;
          F3_SLTU: alu_control = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      CLS_MEM: illegal = (funct3 != F3_WORD);
      CLS_BR: begin
        case (funct3)
          F3_BEQ, F3_BNE: alu_control = ALU_SUB;
          F3_BLT:         alu_control = ALU_SLT;
          F3_BLTU:        alu_control = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB controller for the 32-bit RISC datapath.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to park in TRAP on illegal instructions instead of skipping them.
module alu_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        MemReady,
  input  logic        Zero,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSel,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemTimeout,
  output logic        Illegal
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam state_e S_ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_e S_ILLEGAL_NEXT = S_FETCH;
`endif

  state_e        state, state_next;
  op_class_e     op_class;
  logic [CW-1:0] wait_cnt;
  logic          in_wait, timeout;
  logic [3:0]    dec_alu_control;
  logic          dec_illegal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign funct7_b5    = Instr[30];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  alu_op_decoder u_alu_op_decoder (
    .op_class    (op_class),
    .funct3      (funct3),
    .funct7_b5   (funct7_b5),
    .alu_control (dec_alu_control),
    .illegal     (dec_illegal)
  );

  assign ALUControl = dec_alu_control;

  // A ready memory in the compare cycle completes the access, hence the !MemReady term.
  assign in_wait = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign timeout = (MEM_WAIT_MAX != 0) && in_wait && !MemReady &&
                   (wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so state and counter both see pre-edge values.
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (in_wait && !MemReady)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Outputs decode combinationally so strobes can qualify on MemReady/Zero in the same cycle.
  always_comb begin
    state_next = state;
    op_class   = CLS_NONE;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REGB;
    ImmSel     = IMM_I;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    MemTimeout = 1'b0;
    Illegal    = 1'b0;

    unique case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        op_class = CLS_ADD;
        ALUSrcB  = SRCB_FOUR;
        MemRead  = !timeout;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          MemTimeout = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_DECODE: begin
        op_class = CLS_ADD;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_IMM;
        ImmSel   = IMM_B;
        case (opcode)
          OPC_R:               state_next = S_EXEC_R;
          OPC_I:               state_next = S_EXEC_I;
          OPC_LOAD, OPC_STORE: state_next = S_MEM_ADDR;
          OPC_BRANCH:          state_next = S_BRANCH;
          default:             state_next = S_ILLEGAL_NEXT;
        endcase
      end

      S_EXEC_R: begin
        op_class   = CLS_R;
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_REGB;
        state_next = dec_illegal ? S_ILLEGAL_NEXT : S_ALU_WB;
      end

      S_EXEC_I: begin
        op_class   = CLS_I;
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        ImmSel     = IMM_I;
        state_next = dec_illegal ? S_ILLEGAL_NEXT : S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        op_class = CLS_MEM;
        ALUSrcA  = SRCA_REGA;
        ALUSrcB  = SRCB_IMM;
        ImmSel   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        if (dec_illegal)              state_next = S_ILLEGAL_NEXT;
        else if (opcode == OPC_STORE) state_next = S_MEM_WRITE;
        else                          state_next = S_MEM_READ;
      end

      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = !timeout;
        if (MemReady) begin
          state_next = S_MEM_WB;
        end else if (timeout) begin
          MemTimeout = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = !timeout;
        if (MemReady) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          MemTimeout = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_BRANCH: begin
        op_class = CLS_BR;
        ALUSrcA  = SRCA_REGA;
        ALUSrcB  = SRCB_REGB;
        if (!dec_illegal && branch_taken(funct3, Zero)) begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
        end
        state_next = dec_illegal ? S_ILLEGAL_NEXT : S_FETCH;
      end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        Illegal    = 1'b1;
        state_next = S_TRAP;
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: per-cycle expected output vectors are queued as stimulus
// is driven and compared on the falling edge. Honours ALU_CTRL_ILLEGAL_TRAP_EN like the RTL.
module tb_alu_ctrl_fsm;

  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_AND  = 4'b0010;
  localparam logic [3:0] A_OR   = 4'b0011;
  localparam logic [3:0] A_NOR  = 4'b0100;
  localparam logic [3:0] A_SLT  = 4'b1000;
  localparam logic [3:0] A_SLTU = 4'b1001;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic       pcsrc;
    logic       rw;
    logic       m2r;
    logic       tmo;
    logic       ill;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instr;
  logic        MemReady;
  logic        Zero;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUSrcA, ALUSrcB, ImmSel;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc;
  logic        RegWrite, MemToReg, MemTimeout, Illegal;

  sb_t         q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_instr = '0;

  alu_ctrl_fsm #(.MEM_WAIT_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Instr      (Instr),
    .MemReady   (MemReady),
    .Zero       (Zero),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSel     (ImmSel),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemToReg   (MemToReg),
    .MemTimeout (MemTimeout),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Expected output vectors, one per controller state, written from the state descriptions.
  function automatic outs_t e_idle();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t e_fetch(input logic rdy);
    outs_t o = '0;
    o.mrd = 1'b1; o.srcb = 2'd1; o.irw = rdy; o.pcw = rdy;
    return o;
  endfunction

  function automatic outs_t e_timeout();
    outs_t o = '0;
    o.srcb = 2'd1; o.tmo = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_decode();
    outs_t o = '0;
    o.srca = 2'd2; o.srcb = 2'd2; o.imm = 2'd2;
    return o;
  endfunction

  function automatic outs_t e_exec_r(input logic [3:0] alu);
    outs_t o = '0;
    o.alu = alu; o.srca = 2'd1; o.srcb = 2'd0;
    return o;
  endfunction

  function automatic outs_t e_exec_i(input logic [3:0] alu);
    outs_t o = '0;
    o.alu = alu; o.srca = 2'd1; o.srcb = 2'd2; o.imm = 2'd0;
    return o;
  endfunction

  function automatic outs_t e_alu_wb();
    outs_t o = '0;
    o.rw = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_mem_addr(input logic store);
    outs_t o = '0;
    o.srca = 2'd1; o.srcb = 2'd2; o.imm = store ? 2'd1 : 2'd0;
    return o;
  endfunction

  function automatic outs_t e_mem_read();
    outs_t o = '0;
    o.mrd = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_mem_wb();
    outs_t o = '0;
    o.rw = 1'b1; o.m2r = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_mem_write();
    outs_t o = '0;
    o.mwr = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_branch(input logic [3:0] alu, input logic taken);
    outs_t o = '0;
    o.alu = alu; o.srca = 2'd1; o.srcb = 2'd0; o.pcw = taken; o.pcsrc = taken;
    return o;
  endfunction

  function automatic outs_t e_trap();
    outs_t o = '0;
    o.ill = 1'b1;
    return o;
  endfunction

  // Advance one clock, drive this cycle's inputs, and queue what the outputs must be.
  task automatic step(input logic rn, input logic mr, input logic z, input string tag, input outs_t e);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n    = rn;
    MemReady = mr;
    Zero     = z;
    Instr    = cur_instr;
    s.tag    = tag;
    s.exp    = e;
    q.push_back(s);
  endtask

  task automatic front(input logic [31:0] ins, input string nm, input int waits);
    cur_instr = ins;
    for (int i = 0; i < waits; i++) step(1'b1, 1'b0, 1'b0, {nm, "/fetch_wait"}, e_fetch(1'b0));
    step(1'b1, 1'b1, 1'b0, {nm, "/fetch"}, e_fetch(1'b1));
    step(1'b1, 1'b0, 1'b0, {nm, "/decode"}, e_decode());
  endtask

  task automatic r_op(input logic [31:0] ins, input string nm, input logic [3:0] alu, input int waits);
    front(ins, nm, waits);
    step(1'b1, 1'b0, 1'b0, {nm, "/exec"}, e_exec_r(alu));
    step(1'b1, 1'b0, 1'b0, {nm, "/wb"}, e_alu_wb());
  endtask

  task automatic i_op(input logic [31:0] ins, input string nm, input logic [3:0] alu);
    front(ins, nm, 0);
    step(1'b1, 1'b0, 1'b0, {nm, "/exec"}, e_exec_i(alu));
    step(1'b1, 1'b0, 1'b0, {nm, "/wb"}, e_alu_wb());
  endtask

  task automatic br(input logic [31:0] ins, input string nm, input logic z,
                    input logic [3:0] alu, input logic taken);
    front(ins, nm, 0);
    step(1'b1, 1'b0, z, {nm, "/branch"}, e_branch(alu, taken));
  endtask

  // After an illegal decision: trap build parks in TRAP until reset; default build refetches.
  task automatic illegal_tail(input string nm);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, {nm, "/trap"}, e_trap());
    step(1'b0, 1'b0, 1'b0, {nm, "/trap_rst"}, e_trap());
    step(1'b1, 1'b0, 1'b0, {nm, "/idle"}, e_idle());
`else
    // The caller's next front() checks that FETCH follows immediately.
    n_tests = n_tests + 0;
    if (nm.len() == 0) $display("illegal tail without a name");
`endif
  endtask

  always @(negedge clk) begin
    sb_t   s;
    outs_t got;
    if (q.size() != 0) begin
      s   = q.pop_front();
      got = {ALUControl, ALUSrcA, ALUSrcB, ImmSel, IorD, MemRead, MemWrite,
             IRWrite, PCWrite, PCSrc, RegWrite, MemToReg, MemTimeout, Illegal};
      check(s.tag, got, s.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    MemReady = 1'b0;
    Zero     = 1'b0;
    Instr    = '0;

    step(1'b0, 1'b0, 1'b0, "reset", e_idle());
    step(1'b1, 1'b0, 1'b0, "idle", e_idle());

    // R-type: add, sub, nor, sltu, and; fetch completing on first cycle.
    r_op(32'h002081B3, "add",  A_ADD,  0);
    r_op(32'h402081B3, "sub",  A_SUB,  0);
    r_op(32'h4020C1B3, "nor",  A_NOR,  0);
    r_op(32'h0020B1B3, "sltu", A_SLTU, 0);
    r_op(32'h0020F1B3, "and",  A_AND,  0);

    // I-type.
    i_op(32'h00500093, "addi", A_ADD);
    i_op(32'h00506093, "ori",  A_OR);
    i_op(32'h00502093, "slti", A_SLT);

    // Branches, taken and not taken.
    br(32'h00208063, "beq_z1",  1'b1, A_SUB,  1'b1);
    br(32'h00208063, "beq_z0",  1'b0, A_SUB,  1'b0);
    br(32'h00209063, "bne_z0",  1'b0, A_SUB,  1'b1);
    br(32'h0020C063, "blt_z1",  1'b1, A_SLT,  1'b0);
    br(32'h0020E063, "bltu_z0", 1'b0, A_SLTU, 1'b1);

    // lw with 2 fetch waits and 3 data waits: MemRead held 4 cycles in MEM_READ.
    front(32'h0080A283, "lw", 2);
    step(1'b1, 1'b0, 1'b0, "lw/addr", e_mem_addr(1'b0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "lw/read_wait", e_mem_read());
    step(1'b1, 1'b1, 1'b0, "lw/read", e_mem_read());
    step(1'b1, 1'b0, 1'b0, "lw/wb", e_mem_wb());

    // sw completing immediately.
    front(32'h0020A223, "sw", 0);
    step(1'b1, 1'b0, 1'b0, "sw/addr", e_mem_addr(1'b1));
    step(1'b1, 1'b1, 1'b0, "sw/write", e_mem_write());

    // Ready on the compare cycle: completion wins, no timeout.
    r_op(32'h002081B3, "add_w4", A_ADD, 4);

    // Fetch timeout after 4 waits, then retry from IDLE.
    cur_instr = 32'h002081B3;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "tmo/fetch_wait", e_fetch(1'b0));
    step(1'b1, 1'b0, 1'b0, "tmo/pulse", e_timeout());
    step(1'b1, 1'b0, 1'b0, "tmo/idle", e_idle());
    r_op(32'h002081B3, "add_retry", A_ADD, 0);

    // Reset during MEM_WRITE drops MemWrite after that edge.
    front(32'h0020A223, "sw_rst", 0);
    step(1'b1, 1'b0, 1'b0, "sw_rst/addr", e_mem_addr(1'b1));
    step(1'b1, 1'b0, 1'b0, "sw_rst/write_wait", e_mem_write());
    step(1'b1, 1'b0, 1'b0, "sw_rst/write_wait", e_mem_write());
    step(1'b0, 1'b0, 1'b0, "sw_rst/rst_low", e_mem_write());
    step(1'b1, 1'b0, 1'b0, "sw_rst/idle", e_idle());

    // Illegal opcode, illegal R funct, illegal branch funct3.
    front(32'h0000007F, "ill_opc", 0);
    illegal_tail("ill_opc");
    front(32'h002091B3, "ill_r", 0);
    step(1'b1, 1'b0, 1'b0, "ill_r/exec", e_exec_r(A_ADD));
    illegal_tail("ill_r");
    front(32'h0020A063, "ill_br", 0);
    step(1'b1, 1'b0, 1'b1, "ill_br/branch", e_branch(A_ADD, 1'b0));
    illegal_tail("ill_br");

    r_op(32'h402081B3, "sub_end", A_SUB, 0);

    @(negedge clk);
    #1;
    check("sb_drain", 20'(q.size()), 20'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
